// File: rtl/imem_loader.sv
// Boot-time IMEM loader: packs a little-endian byte stream into 32-bit words,
// writes them to consecutive word addresses and holds the core in reset until done.
//
// state   | meaning
// IDLE    | waiting for the first byte of an image
// COLLECT | accumulating bytes of the current word
// WRITE   | one-cycle IMEM write of the assembled word
// DONE    | image loaded, core released from reset
// ERROR   | image exceeded IMEM capacity, core held in reset
module imem_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_COUNT = 64,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [7:0]            s_data,
  input  logic                  s_last,
  input  logic                  start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset_n,
  output logic                  load_done,
  output logic                  overflow_err,
  output logic [CNT_WIDTH-1:0]  word_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } state_t;

  state_t               state, state_next;
  logic [1:0]           lane;
  logic [CNT_WIDTH-1:0] word_idx;
  logic [31:0]          buffer;
  logic [31:0]          buf_merged;
  logic                 wr_last;
  logic                 xfer;
  logic                 full;

  assign s_ready    = (state == IDLE) || (state == COLLECT);
  assign xfer       = s_valid && s_ready;
  assign full       = (word_idx == CNT_WIDTH'(WORD_COUNT));
  assign word_count = word_idx;

  always_comb begin
    buf_merged = buffer;
    buf_merged[{lane, 3'b000} +: 8] = s_data;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, COLLECT: begin
        if (xfer) begin
          if (full)
            state_next = ERROR;
          else if ((lane == 2'd3) || s_last)
            state_next = WRITE;
          else
            state_next = COLLECT;
        end
      end
      WRITE:       state_next = wr_last ? DONE : COLLECT;
      DONE, ERROR: if (start) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane         <= 2'd0;
      word_idx     <= '0;
      buffer       <= 32'd0;
      wr_last      <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      cpu_reset_n  <= 1'b0;
      load_done    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (xfer && full) begin
            // Byte past capacity is dropped; nothing is written.
            overflow_err <= 1'b1;
          end else if (xfer) begin
            buffer  <= buf_merged;
            lane    <= lane + 2'd1;
            wr_last <= s_last;
            if (state_next == WRITE) begin
              imem_we    <= 1'b1;
              imem_addr  <= ADDR_WIDTH'(word_idx) << 2;
              imem_wdata <= buf_merged;
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 1'b1;
          buffer   <= 32'd0;
          lane     <= 2'd0;
          if (wr_last) begin
            load_done   <= 1'b1;
            cpu_reset_n <= 1'b1;
          end
        end
        DONE, ERROR: begin
          if (start) begin
            lane         <= 2'd0;
            word_idx     <= '0;
            buffer       <= 32'd0;
            wr_last      <= 1'b0;
            load_done    <= 1'b0;
            overflow_err <= 1'b0;
            cpu_reset_n  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a two-word IMEM so overflow is reachable.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid, s_ready, s_last, start;
  logic [7:0]  s_data;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic        cpu_reset_n, load_done, overflow_err;
  logic [6:0]  word_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_loader #(.ADDR_WIDTH(32), .WORD_COUNT(2), .CNT_WIDTH(7)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .start(start), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset_n(cpu_reset_n),
    .load_done(load_done), .overflow_err(overflow_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Record every write; while loading, s_ready must be low exactly in WRITE cycles.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    if (!reset && !load_done && !overflow_err)
      chk("ready_vs_we", {31'd0, s_ready}, {31'd0, ~imem_we});
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    @(negedge clk);
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'hxx;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_image(input logic [7:0] img[], input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      send_byte(img[i], i == n - 1);
      if (gap) idle_cycles(1);
    end
  endtask

  task automatic clear_q();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  logic [7:0] img8[] = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
  logic [7:0] img6[] = '{8'h13, 8'h01, 8'h50, 8'h00, 8'hEF, 8'hBE};
  logic [7:0] img9[] = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00, 8'h55};
  logic [7:0] img4[] = '{8'h78, 8'h56, 8'h34, 8'h12};

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_cpu_rst_n", {31'd0, cpu_reset_n}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_wcount", {25'd0, word_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // single word, continuous valid, exact write latency
    send_byte(8'h13, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h50, 1'b0);
    send_byte(8'h00, 1'b1);
    @(negedge clk);
    chk("t1_we", {31'd0, imem_we}, 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_wdata", imem_wdata, 32'h00500113);
    chk("t1_ready_wr", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    chk("t1_done", {31'd0, load_done}, 32'd1);
    chk("t1_cpu_rst_n", {31'd0, cpu_reset_n}, 32'd1);
    chk("t1_wcount", {25'd0, word_count}, 32'd1);
    chk("t1_we_low", {31'd0, imem_we}, 32'd0);
    @(posedge clk); #1;

    // two words with valid toggling every cycle
    pulse_start();
    clear_q();
    send_image(img8, 8, 1'b1);
    idle_cycles(2);
    chk("t2_nwr", wr_addr_q.size(), 32'd2);
    chk("t2_a0", wr_addr_q[0], 32'h0);
    chk("t2_d0", wr_data_q[0], 32'h00500113);
    chk("t2_a1", wr_addr_q[1], 32'h4);
    chk("t2_d1", wr_data_q[1], 32'h00C00193);
    chk("t2_done", {31'd0, load_done}, 32'd1);
    chk("t2_wcount", {25'd0, word_count}, 32'd2);

    // partial final word
    pulse_start();
    clear_q();
    send_image(img6, 6, 1'b0);
    idle_cycles(2);
    chk("t3_nwr", wr_addr_q.size(), 32'd2);
    chk("t3_a1", wr_addr_q[1], 32'h4);
    chk("t3_d1", wr_data_q[1], 32'h0000BEEF);
    chk("t3_done", {31'd0, load_done}, 32'd1);

    // overflow with capacity 2 words
    pulse_start();
    clear_q();
    send_image(img9, 9, 1'b0);
    idle_cycles(2);
    chk("t4_nwr", wr_addr_q.size(), 32'd2);
    chk("t4_ovf", {31'd0, overflow_err}, 32'd1);
    chk("t4_done", {31'd0, load_done}, 32'd0);
    chk("t4_cpu_rst_n", {31'd0, cpu_reset_n}, 32'd0);
    chk("t4_ready", {31'd0, s_ready}, 32'd0);
    pulse_start();
    @(negedge clk);
    chk("t4_clr_ovf", {31'd0, overflow_err}, 32'd0);
    chk("t4_clr_wcount", {25'd0, word_count}, 32'd0);
    chk("t4_clr_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;

    // async reset mid-image, then full reload
    clear_q();
    for (int i = 0; i < 6; i++) send_byte(img8[i], 1'b0);
    chk("t5_pre_wcount", {25'd0, word_count}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_wcount", {25'd0, word_count}, 32'd0);
    chk("t5_addr", imem_addr, 32'h0);
    chk("t5_wdata", imem_wdata, 32'h0);
    chk("t5_ready", {31'd0, s_ready}, 32'd1);
    chk("t5_cpu_rst_n", {31'd0, cpu_reset_n}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_q();
    send_image(img8, 8, 1'b0);
    idle_cycles(2);
    chk("t5_nwr", wr_addr_q.size(), 32'd2);
    chk("t5_a0", wr_addr_q[0], 32'h0);
    chk("t5_d0", wr_data_q[0], 32'h00500113);
    chk("t5_a1", wr_addr_q[1], 32'h4);
    chk("t5_d1", wr_data_q[1], 32'h00C00193);

    // start ignored in COLLECT
    pulse_start();
    clear_q();
    send_byte(8'h13, 1'b0);
    send_byte(8'h01, 1'b0);
    pulse_start();
    send_byte(8'h50, 1'b0);
    send_byte(8'h00, 1'b1);
    idle_cycles(2);
    chk("t6_nwr", wr_addr_q.size(), 32'd1);
    chk("t6_d0", wr_data_q[0], 32'h00500113);
    chk("t6_done", {31'd0, load_done}, 32'd1);
    pulse_start();
    @(negedge clk);
    chk("t6_clr_done", {31'd0, load_done}, 32'd0);
    chk("t6_clr_cpu", {31'd0, cpu_reset_n}, 32'd0);
    @(posedge clk); #1;
    clear_q();
    send_image(img4, 4, 1'b0);
    idle_cycles(2);
    chk("t6_a0", wr_addr_q[0], 32'h0);
    chk("t6_d0b", wr_data_q[0], 32'h12345678);
    chk("t6_wcount", {25'd0, word_count}, 32'd1);

    // s_last without s_valid ignored; single-byte image
    pulse_start();
    clear_q();
    s_last = 1'b1;
    idle_cycles(2);
    s_last = 1'b0;
    chk("t7_nowr", wr_addr_q.size(), 32'd0);
    chk("t7_ready", {31'd0, s_ready}, 32'd1);
    send_byte(8'hAB, 1'b1);
    idle_cycles(2);
    chk("t7_d0", wr_data_q[0], 32'h000000AB);
    chk("t7_done", {31'd0, load_done}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader: the write side of instruction memory, which the single-cycle RISCV core only reads. Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words. Writes each word to consecutive IMEM word addresses and holds the core in reset until the whole image is written. Replaces simulation-only memory preload, so the same machine-code image can be loaded in hardware and then checked by the existing regfile/PC/DMEM checks.

Parameters:
ADDR_WIDTH, 32, width of imem_addr (byte address, word-aligned)
WORD_COUNT, 64, IMEM capacity in 32-bit words; max image size
CNT_WIDTH, 7, width of word_count; must hold 0..WORD_COUNT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
s_valid  in  1  byte on s_data valid
s_ready  out  1  loader can accept a byte this cycle
s_data  in  8  image byte, in increasing address order
s_last  in  1  qualifies the final byte of the image
start  in  1  single-cycle pulse; restarts loading from DONE or ERROR
imem_we  out  1  IMEM write strobe, one cycle per word
imem_addr  out  ADDR_WIDTH  byte address of the word being written (word_idx*4)
imem_wdata  out  32  word being written
cpu_reset_n  out  1  active-low reset to RISCV core; 1 only in DONE
load_done  out  1  image fully written
overflow_err  out  1  image exceeded WORD_COUNT words
word_count  out  CNT_WIDTH  number of words written so far

Behaviour:
- Reset (async, any state): state=IDLE, lane=0, word_idx=0, word buffer=0. Outputs: s_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset_n=0, load_done=0, overflow_err=0, word_count=0.
- All outputs are registered except s_ready, which is decoded from state only.
- A byte transfer occurs on a rising edge with s_valid=1 and s_ready=1.
- The byte accepted at lane k goes to buffer bits [8k+7:8k] (little-endian); lane then increments mod 4.
- States:
  - IDLE: s_ready=1. First transfer → COLLECT, with the byte handled as in COLLECT.
  - COLLECT: s_ready=1. Transfer on lane 3, or any transfer with s_last=1 → WRITE. Otherwise stay.
  - WRITE: exactly one cycle. s_ready=0, imem_we=1, imem_addr=word_idx*4, imem_wdata=buffer. IMEM commits on the next edge; at that edge word_idx and word_count increment, buffer and lane clear. Go to DONE if the word carried s_last, else COLLECT.
  - DONE: s_ready=0, load_done=1, cpu_reset_n=1. Hold until start.
  - ERROR: s_ready=0, overflow_err=1, cpu_reset_n=0. Hold until start.
- Write latency: imem_we asserts in the cycle after the edge that accepted the 4th byte, or the s_last byte.
- Partial final word: lanes not written are 0 (e.g. a single s_last byte 0xAB gives wdata 0x000000AB).
- Overflow: a transfer accepted while word_idx==WORD_COUNT is discarded, no write occurs, state → ERROR. This applies even if s_last=1.
- An image of exactly WORD_COUNT words ending with s_last → DONE, not ERROR.
- start: honoured only in DONE or ERROR. Next state is IDLE with lane, word_idx, word_count and flags cleared and cpu_reset_n=0. Ignored in IDLE, COLLECT and WRITE.
- s_last without s_valid is ignored. s_data is don't-care when s_valid=0.
- Throughput: 4 bytes + 1 WRITE cycle per word, i.e. 5 cycles/word with continuous s_valid.
- reset asserted mid-image: immediate return to the reset values above, and cpu_reset_n drops to 0 asynchronously. A word already committed to IMEM stays in IMEM; the loader does not scrub memory.

Test Plan:
- Bytes 13 01 50 00 (s_last on 4th), continuous valid → one imem_we pulse, addr=0x0, wdata=0x00500113. Next cycle load_done=1, cpu_reset_n=1, word_count=1.
- Image 13 01 50 00 93 01 C0 00 with s_valid toggling 1/0 each cycle → writes 0x00500113@0x0 and 0x00C00193@0x4. s_ready=0 exactly in each WRITE cycle. No byte lost or duplicated.
- 6-byte image ending 0xEF 0xBE with s_last → second write addr=0x4, wdata=0x0000BEEF, then DONE.
- WORD_COUNT=2, send 9 bytes with s_last on the 9th → two writes only, then overflow_err=1, load_done=0, cpu_reset_n=0. start pulse → IDLE with all flags and word_count back to 0.
- Assert reset for 1 cycle after 6 of 8 bytes → outputs at reset values immediately. Reload of the full 8-byte image writes addr 0x0 then 0x4 correctly.
- start pulsed while in COLLECT → ignored, image completes normally. Pulse start in DONE, reload a 4-byte image → a fresh write at addr 0x0 and word_count=1.
